regfile_reader: RTL and testbench

Sequential read-side companion to `regfile`: on a start request it walks a contiguous, wrapping range of register-file addresses through the file's combinational read port and streams each word out over a valid/ready interface. It sits between a `regfile` instance (driving its `read_addr`, consuming its `read_data`) and any downstream consumer, for example a debug dump or a serializer. It owns the read port while busy; the write port stays with the rest of the design.

---
 rtl/regfile_reader.sv | 115 +++++++++++
 tb/tb_regfile_reader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_reader.sv
// Sequential dump engine for a regfile: walks a wrapping address range through the
// combinational read port and streams each word out over valid/ready.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

module regfile_reader #(
    parameter int unsigned n    = `DEFAULT_WIDTH,
    parameter int unsigned bits = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [bits-1:0] start_addr,
    input  logic [bits:0]   length,
    output logic [bits-1:0] read_addr,
    input  logic [n-1:0]    read_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [n-1:0]    out_data,
    output logic [bits-1:0] out_addr,
    output logic            out_last,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

    state_e          state_q, state_d;
    logic [bits-1:0] read_addr_q, read_addr_d;
    logic [bits:0]   remaining_q, remaining_d;
    logic [n-1:0]    data_q, data_d;
    logic [bits-1:0] addr_q, addr_d;
    logic            last_q, last_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            read_addr_q <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            addr_q      <= '0;
            last_q      <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            read_addr_q <= read_addr_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            last_q      <= last_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        read_addr_d = read_addr_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        addr_d      = addr_q;
        last_d      = last_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (length != '0) begin
                        read_addr_d = start_addr;
                        remaining_d = length;
                        state_d     = StLoad;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                data_d  = read_data;
                addr_d  = read_addr_q;
                last_d  = (remaining_q == (bits+1)'(1));
                valid_d = 1'b1;
                state_d = StSend;
            end
            StSend: begin
                // out_valid is always high in this state, so out_ready alone is the handshake
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (remaining_q == (bits+1)'(1)) begin
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        read_addr_d = read_addr_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                        state_d     = StLoad;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign read_addr = read_addr_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_addr  = addr_q;
    assign out_last  = last_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

endmodule

// File: tb/tb_regfile_reader.sv
// Scoreboard bench for regfile_reader: a bench-side register file feeds the read port,
// expected words are queued at start and popped by a monitor on every handshake.
module tb_regfile_reader;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] start_addr;
    logic [3:0] length;
    logic [2:0] read_addr;
    logic [7:0] read_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_addr;
    logic       out_last;
    logic       busy;
    logic       done;

    logic [7:0] mem [8];
    assign read_data = mem[read_addr];

    regfile_reader #(.n(8), .bits(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
        logic       last;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   done_count = 0;
    bit   mon_en = 1'b0;
    bit   rdy_rand = 1'b0;
    bit   zero_pend = 1'b0;
    bit   done_due = 1'b0;
    bit   gap_due = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: done timing, valid gap and scoreboard pop on each handshake
    initial begin
        forever begin
            @(negedge clock);
            if (mon_en) begin
                chk("done_pulse", {31'b0, done}, {31'b0, done_due});
                if (done) begin
                    chk("busy_at_done", {31'b0, busy}, 32'd0);
                    done_count++;
                end
                if (gap_due) chk("valid_gap", {31'b0, out_valid}, 32'd0);
                done_due = 1'b0;
                gap_due  = 1'b0;
                if (reset) begin
                    q.delete();
                    zero_pend = 1'b0;
                end else begin
                    if (zero_pend) begin
                        done_due  = 1'b1;
                        zero_pend = 1'b0;
                    end
                    if (out_valid && out_ready) begin
                        if (q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_word: got addr %0h data %0h, none expected",
                                     out_addr, out_data);
                        end else begin
                            ent_t e;
                            e = q.pop_front();
                            chk("word_data", {24'b0, out_data}, {24'b0, e.data});
                            chk("word_addr", {29'b0, out_addr}, {29'b0, e.addr});
                            chk("word_last", {31'b0, out_last}, {31'b0, e.last});
                            if (e.last) done_due = 1'b1;
                        end
                        gap_due = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic push_exp(input int sa, input int len);
        for (int i = 0; i < len; i++) begin
            ent_t e;
            e.addr = 3'((sa + i) % 8);
            e.data = mem[e.addr];
            e.last = (i == len - 1);
            q.push_back(e);
        end
    endtask

    task automatic kick(input int sa, input int len);
        @(posedge clock);
        #1;
        start      = 1'b1;
        start_addr = 3'(sa);
        length     = 4'(len);
        if (len == 0) zero_pend = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("busy_after_start", {31'b0, busy}, {31'b0, (len != 0)});
    endtask

    task automatic wait_idle();
        int cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while ((q.size() != 0 || busy) && cyc < 1000);
        if (cyc >= 1000) begin
            checks++;
            failures++;
            $display("FAIL timeout_idle: %0d words outstanding, busy %0b", q.size(), busy);
        end
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic wait_qsize(input int sz);
        int cyc = 0;
        while (q.size() > sz && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        if (cyc >= 200) begin
            checks++;
            failures++;
            $display("FAIL timeout_qsize: got %0d required %0d", q.size(), sz);
        end
    endtask

    task automatic wait_valid_addr(input logic [2:0] a);
        int cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!(out_valid && out_addr == a) && cyc < 200);
        if (cyc >= 200) begin
            checks++;
            failures++;
            $display("FAIL timeout_valid: addr %0h never presented", a);
        end
    endtask

    task automatic dump(input int sa, input int len);
        int dc0;
        push_exp(sa, len);
        dc0 = done_count;
        kick(sa, len);
        wait_idle();
        chk("done_count", done_count - dc0, 32'd1);
    endtask

    task automatic init_mem();
        for (int i = 0; i < 8; i++) mem[i] = 8'(17 * i);
    endtask

    initial begin
        int dc0;
        reset      = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        length     = '0;
        out_ready  = 1'b1;
        init_mem();
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_read_addr", {29'b0, read_addr}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {24'b0, out_data}, 32'd0);
        chk("rst_out_addr", {29'b0, out_addr}, 32'd0);
        chk("rst_out_last", {31'b0, out_last}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        mon_en = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Full dump and wrap
        dump(0, 8);
        dump(6, 4);

        // Backpressure on the second word
        push_exp(0, 8);
        dc0 = done_count;
        kick(0, 8);
        wait_qsize(7);
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        wait_valid_addr(3'd1);
        repeat (5) begin
            chk("hold_data", {24'b0, out_data}, 32'h11);
            chk("hold_addr", {29'b0, out_addr}, 32'd1);
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        wait_idle();
        chk("done_count_bp", done_count - dc0, 32'd1);

        // Zero length
        dump(3, 0);

        // Start pulsed mid-dump is ignored
        push_exp(2, 5);
        dc0 = done_count;
        kick(2, 5);
        repeat (3) @(posedge clock);
        #1;
        start      = 1'b1;
        start_addr = 3'd4;
        length     = 4'd3;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_idle();
        chk("done_count_mid", done_count - dc0, 32'd1);

        // Reset during SEND of the third word
        push_exp(0, 8);
        dc0 = done_count;
        kick(0, 8);
        wait_qsize(6);
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        wait_valid_addr(3'd2);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("abort_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_data", {24'b0, out_data}, 32'd0);
        chk("abort_addr", {29'b0, out_addr}, 32'd0);
        chk("abort_read_addr", {29'b0, read_addr}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        repeat (2) @(negedge clock);
        chk("abort_no_done", done_count - dc0, 32'd0);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        dump(0, 8);

        // Write to file[5] while word 2 is in SEND
        push_exp(0, 8);
        dc0 = done_count;
        kick(0, 8);
        wait_qsize(6);
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        wait_valid_addr(3'd2);
        mem[5] = 8'hA5;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].addr == 3'd5) q[i].data = 8'hA5;
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        wait_idle();
        chk("done_count_wr", done_count - dc0, 32'd1);

        // Randomized dumps with random backpressure and file contents
        rdy_rand = 1'b1;
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
            dump(int'($urandom_range(0, 7)), int'($urandom_range(0, 8)));
        end
        rdy_rand = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
